// File: rtl/pcs_rx_cmd_decoder.sv
// PCS receive command decoder: SYNC-prefixed BEACON/COMMIT/HEARTBEAT detection plus heartbeat watchdog.
// Latency 1 beat to rx_cmd/rx_cmd_new; no backpressure (invalid beats hold state). Stats via RX_CMD_STATS_EN.
module pcs_rx_cmd_decoder #(
    parameter int         SYNC_MIN      = 2,
    parameter int         HB_TIMEOUT    = 4000,
    parameter logic [4:0] SYM_SYNC      = 5'b11000,
    parameter logic [4:0] SYM_BEACON    = 5'b01000,
    parameter logic [4:0] SYM_COMMIT    = 5'b10001,
    parameter logic [4:0] SYM_HEARTBEAT = 5'b00100
) (
    input  logic        clk,
    input  logic        pcs_reset,
    input  logic [4:0]  rx_sym,
    input  logic        rx_sym_valid,
    input  logic        hb_mon_en,
    output logic [1:0]  rx_cmd,
    output logic        rx_cmd_new,
    output logic        hb_lost,
    output logic [15:0] beacon_cnt,
    output logic [15:0] commit_cnt,
    output logic [15:0] heartbeat_cnt
);

    localparam int                    HB_CNT_W   = $clog2(HB_TIMEOUT + 1);
    localparam logic [HB_CNT_W-1:0]   HB_MAX     = HB_CNT_W'(HB_TIMEOUT);
    localparam logic [HB_CNT_W-1:0]   HB_ONE     = HB_CNT_W'(1);
    localparam logic [2:0]            SYNC_MIN_L = 3'(SYNC_MIN);

    localparam logic [1:0] CMD_BEACON    = 2'b00;
    localparam logic [1:0] CMD_COMMIT    = 2'b01;
    localparam logic [1:0] CMD_HEARTBEAT = 2'b10;
    localparam logic [1:0] CMD_NONE      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNCING = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sync_cnt_q, sync_cnt_d;
    logic [1:0]          rx_cmd_q, rx_cmd_d;
    logic                rx_cmd_new_q, rx_cmd_new_d;
    logic [HB_CNT_W-1:0] hb_cnt_q, hb_cnt_d;
    logic                hb_lost_q, hb_lost_d;

    logic                is_sync;
    logic                is_cmd;
    logic [1:0]          sym_cmd;
    logic                cmd_load;
    logic                hb_latch;

    always_comb begin
        is_sync = (rx_sym == SYM_SYNC);
        is_cmd  = 1'b1;
        sym_cmd = CMD_NONE;
        if (rx_sym == SYM_BEACON) begin
            sym_cmd = CMD_BEACON;
        end else if (rx_sym == SYM_COMMIT) begin
            sym_cmd = CMD_COMMIT;
        end else if (rx_sym == SYM_HEARTBEAT) begin
            sym_cmd = CMD_HEARTBEAT;
        end else begin
            is_cmd = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        rx_cmd_d     = rx_cmd_q;
        rx_cmd_new_d = 1'b0;
        cmd_load     = 1'b0;
        if (rx_sym_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_sync) begin
                        state_d    = ST_SYNCING;
                        sync_cnt_d = 3'd1;
                    end
                end
                ST_SYNCING: begin
                    if (is_sync) begin
                        sync_cnt_d = (sync_cnt_q == 3'd7) ? 3'd7 : sync_cnt_q + 3'd1;
                    end else if (is_cmd && (sync_cnt_q >= SYNC_MIN_L)) begin
                        state_d    = ST_ACTIVE;
                        sync_cnt_d = 3'd0;
                        cmd_load   = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        sync_cnt_d = 3'd0;
                    end
                end
                ST_ACTIVE: begin
                    // SYNC and a repeat of the current command both keep the command held
                    if (is_cmd) begin
                        cmd_load = (sym_cmd != rx_cmd_q);
                    end else if (!is_sync) begin
                        state_d    = ST_IDLE;
                        sync_cnt_d = 3'd0;
                        rx_cmd_d   = CMD_NONE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    sync_cnt_d = 3'd0;
                    rx_cmd_d   = CMD_NONE;
                end
            endcase
        end
        if (cmd_load) begin
            rx_cmd_d     = sym_cmd;
            rx_cmd_new_d = 1'b1;
        end
    end

    assign hb_latch = cmd_load && (sym_cmd == CMD_HEARTBEAT);

    // A HEARTBEAT latch beats a timeout landing on the same beat
    always_comb begin
        hb_cnt_d  = hb_cnt_q;
        hb_lost_d = hb_lost_q;
        if (!hb_mon_en) begin
            hb_cnt_d  = '0;
            hb_lost_d = 1'b0;
        end else if (rx_sym_valid) begin
            if (hb_latch) begin
                hb_cnt_d  = '0;
                hb_lost_d = 1'b0;
            end else if (hb_cnt_q != HB_MAX) begin
                hb_cnt_d = hb_cnt_q + HB_ONE;
                if (hb_cnt_q + HB_ONE == HB_MAX) begin
                    hb_lost_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pcs_reset) begin
            state_q      <= ST_IDLE;
            sync_cnt_q   <= 3'd0;
            rx_cmd_q     <= CMD_NONE;
            rx_cmd_new_q <= 1'b0;
            hb_cnt_q     <= '0;
            hb_lost_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            rx_cmd_q     <= rx_cmd_d;
            rx_cmd_new_q <= rx_cmd_new_d;
            hb_cnt_q     <= hb_cnt_d;
            hb_lost_q    <= hb_lost_d;
        end
    end

    assign rx_cmd     = rx_cmd_q;
    assign rx_cmd_new = rx_cmd_new_q;
    assign hb_lost    = hb_lost_q;

`ifdef RX_CMD_STATS_EN
    logic [15:0] beacon_cnt_q, beacon_cnt_d;
    logic [15:0] commit_cnt_q, commit_cnt_d;
    logic [15:0] heartbeat_cnt_q, heartbeat_cnt_d;

    // Counters step alongside the rx_cmd_new pulse they account for
    always_comb begin
        beacon_cnt_d    = beacon_cnt_q;
        commit_cnt_d    = commit_cnt_q;
        heartbeat_cnt_d = heartbeat_cnt_q;
        if (rx_cmd_new_d) begin
            case (rx_cmd_d)
                CMD_BEACON:    if (beacon_cnt_q != 16'hFFFF) beacon_cnt_d = beacon_cnt_q + 16'd1;
                CMD_COMMIT:    if (commit_cnt_q != 16'hFFFF) commit_cnt_d = commit_cnt_q + 16'd1;
                CMD_HEARTBEAT: if (heartbeat_cnt_q != 16'hFFFF) heartbeat_cnt_d = heartbeat_cnt_q + 16'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pcs_reset) begin
            beacon_cnt_q    <= 16'd0;
            commit_cnt_q    <= 16'd0;
            heartbeat_cnt_q <= 16'd0;
        end else begin
            beacon_cnt_q    <= beacon_cnt_d;
            commit_cnt_q    <= commit_cnt_d;
            heartbeat_cnt_q <= heartbeat_cnt_d;
        end
    end

    assign beacon_cnt    = beacon_cnt_q;
    assign commit_cnt    = commit_cnt_q;
    assign heartbeat_cnt = heartbeat_cnt_q;
`else
    assign beacon_cnt    = 16'd0;
    assign commit_cnt    = 16'd0;
    assign heartbeat_cnt = 16'd0;
`endif

endmodule

// File: doc/pcs_rx_cmd_decoder.md
Name: pcs_rx_cmd_decoder

Overview:
- Receive-side counterpart of the heartbeat/command transmit path.
- Watches received 5B code-groups from the PCS receive path and detects SYNC-prefixed command sequences.
- Drives `rx_cmd` (BEACON/COMMIT/HEARTBEAT/NONE) for the heartbeat and PLCA state machines.
- Supervises heartbeat arrival and flags a lost link partner heartbeat.

Parameters:
- SYNC_MIN, 2, consecutive SYNC code-groups required before a command symbol is accepted (1..7)
- HB_TIMEOUT, 4000, received code-group beats without HEARTBEAT before `hb_lost` asserts (>=2)
- SYM_SYNC, 5'b11000, SYNC code-group (J)
- SYM_BEACON, 5'b01000, BEACON command code-group
- SYM_COMMIT, 5'b10001, COMMIT command code-group
- SYM_HEARTBEAT, 5'b00100, HEARTBEAT command code-group

Ports:
- clk  input  1  PCS clock; all logic on rising edge
- pcs_reset  input  1  synchronous, active-high reset
- rx_sym  input  5  received 5B code-group
- rx_sym_valid  input  1  `rx_sym` qualifier, one beat per code-group
- hb_mon_en  input  1  enables heartbeat supervision
- rx_cmd  output  2  00 BEACON, 01 COMMIT, 10 HEARTBEAT, 11 NONE
- rx_cmd_new  output  1  one-cycle pulse when `rx_cmd` changes to a non-NONE value
- hb_lost  output  1  heartbeat timeout flag
- beacon_cnt  output  16  BEACON detections (see Optional Feature)
- commit_cnt  output  16  COMMIT detections (see Optional Feature)
- heartbeat_cnt  output  16  HEARTBEAT detections (see Optional Feature)

Behaviour:
- Reset values:
  - state = IDLE, `sync_cnt` = 0, `rx_cmd` = NONE (2'b11)
  - `rx_cmd_new` = 0, `hb_lost` = 0, `hb_cnt` = 0, all stats counters = 0
  - `pcs_reset` mid-sequence aborts immediately; no partial command is reported.
- Only beats with `rx_sym_valid` = 1 advance the FSM or the watchdog. Invalid beats hold all state.
- `sync_cnt` is 3 bits and saturates at 7.
- FSM states and transitions:
  - IDLE:
    - SYNC -> SYNCING, `sync_cnt` = 1.
    - Any other symbol -> stay.
  - SYNCING:
    - SYNC -> `sync_cnt` += 1.
    - Command symbol with `sync_cnt` >= SYNC_MIN -> ACTIVE; latch the command.
    - Command symbol with `sync_cnt` < SYNC_MIN -> IDLE.
    - Any other symbol -> IDLE.
  - ACTIVE:
    - Same command symbol or SYNC -> stay; `rx_cmd` held.
    - Different command symbol -> ACTIVE with the new command; re-pulse `rx_cmd_new`.
    - Any other symbol -> IDLE, `rx_cmd` = NONE.
- Output timing:
  - `rx_cmd` is registered and updates on the cycle after the qualifying beat (latency 1).
  - `rx_cmd_new` pulses in that same cycle.
  - Return to NONE also has latency 1.
- Heartbeat watchdog:
  - `hb_cnt` is sized for HB_TIMEOUT and increments per valid beat while `hb_mon_en` = 1.
  - `hb_cnt` clears to 0 on the beat that latches HEARTBEAT.
  - When `hb_cnt` reaches HB_TIMEOUT, `hb_lost` = 1 and the counter holds.
  - `hb_lost` is sticky until the next HEARTBEAT detection, which clears it with latency 1.
  - `hb_mon_en` = 0 forces `hb_cnt` = 0 and `hb_lost` = 0.
  - A HEARTBEAT on the same beat the count reaches HB_TIMEOUT takes priority: counter clears, `hb_lost` stays 0.
- Simultaneous `pcs_reset` and valid beat: reset wins.

Optional Feature:
- Macro: RX_CMD_STATS_EN.
- Defined:
  - `beacon_cnt`, `commit_cnt` and `heartbeat_cnt` each increment by 1 on every `rx_cmd_new` pulse for their command.
  - Counters saturate at 16'hFFFF and clear on `pcs_reset`.
- Not defined: the three ports are tied to 0 and no counter logic is built.

Test Plan:
- SYNC_MIN = 2; drive SYNC, SYNC, HEARTBEAT -> `rx_cmd` = 2'b10 and `rx_cmd_new` = 1 one cycle after the HEARTBEAT beat; the next symbol 5'b11111 returns `rx_cmd` to 2'b11 one cycle later.
- Drive SYNC, BEACON (only 1 SYNC) -> `rx_cmd` stays 2'b11 and `rx_cmd_new` never pulses; then SYNC, SYNC, SYNC, BEACON -> `rx_cmd` = 2'b00.
- In ACTIVE(COMMIT), drive SYNC, COMMIT, BEACON -> `rx_cmd` holds 2'b01 through SYNC/COMMIT, then 2'b00 with a second `rx_cmd_new` pulse.
- HB_TIMEOUT = 8, `hb_mon_en` = 1, drive 8 valid idle beats -> `hb_lost` = 1 after the 8th; SYNC, SYNC, HEARTBEAT -> `hb_lost` = 0 one cycle later; dropping `hb_mon_en` during a count clears `hb_cnt`.
- Drive SYNC, SYNC, then assert `pcs_reset` on the HEARTBEAT beat -> `rx_cmd` = 2'b11, no pulse, `hb_lost` = 0; interleave `rx_sym_valid` = 0 beats mid-sequence -> detection unaffected.
- With RX_CMD_STATS_EN: 3 BEACON and 2 HEARTBEAT detections -> `beacon_cnt` = 3, `heartbeat_cnt` = 2, `commit_cnt` = 0; without the macro all counters read 0.
